mem_stage: RTL and testbench

//  MEM pipeline stage, directly downstream of EX. Takes EX's write-back triple plus load/store request
//  (address, length 1/2/4, signed flag) and runs a byte-serial access on the 8-bit memory-controller port.

---
 rtl/mem_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage sitting directly after EX.
//
// Load/store requests from EX become a byte-serial access on the 8-bit
// memory-controller port. Loads are assembled little-endian, then zero- or
// sign-extended. Stores are split into bytes, lowest address first.
// Instructions that do not touch memory pass straight through to write-back
// with zero latency. While an access is in flight, stall_req_o holds IF..EX.
//
// Ports
//   clk, rst (async, active-low), rdy (0 freezes all state)
//   EX side    : wd_i, wreg_i, wdata_i, mem_addr_i, loading_i, storing_i,
//                mem_length_i, mem_signed_i
//   memory side: mem_req_o, mem_we_o, mem_a_o, mem_dout_o, mem_gnt_i, mem_din_i
//   pipeline   : stall_req_o to ctrl; wd_o, wreg_o, wdata_o to write-back
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no access in flight; non-memory instructions pass through
// BUSY   | one byte request per grant, cnt = index of the current byte
// DONE   | single cycle presenting the load result / store completion

module mem_stage #(
   parameter int ADDR_W  = 32,
   parameter int MAX_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic [4:0]        wd_i,
   input  logic              wreg_i,
   input  logic [31:0]       wdata_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic              loading_i,
   input  logic              storing_i,
   input  logic [2:0]        mem_length_i,
   input  logic              mem_signed_i,
   input  logic              mem_gnt_i,
   input  logic [7:0]        mem_din_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_a_o,
   output logic [7:0]        mem_dout_o,
   output logic              stall_req_o,
   output logic [4:0]        wd_o,
   output logic              wreg_o,
   output logic [31:0]       wdata_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [2:0] MAX_LEN_L = 3'(MAX_LEN);

   state_t            state_q, state_d;
   logic [1:0]        cnt_q;
   logic [31:0]       buf_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        len_q;
   logic              signed_q;
   logic [31:0]       data_q;
   logic [4:0]        wd_q;
   logic              wreg_q;
   logic              store_q;

   logic [2:0]        len_in;
   logic              access;
   logic              last_byte;
   logic [31:0]       ext;

   assign len_in    = (mem_length_i > MAX_LEN_L) ? MAX_LEN_L : mem_length_i;
   // A zero-length request is treated as an ordinary pass-through instruction.
   assign access    = (loading_i | storing_i) & (len_in != 3'd0);
   assign last_byte = ({1'b0, cnt_q} == (len_q - 3'd1));

   // Sign bit sits at 8*len-1; bytes above the access length are never read.
   always_comb begin
      ext = buf_q;
      case (len_q)
         3'd1:    ext = {{24{signed_q & buf_q[7]}},  buf_q[7:0]};
         3'd2:    ext = {{16{signed_q & buf_q[15]}}, buf_q[15:0]};
         3'd3:    ext = {{8{signed_q & buf_q[23]}},  buf_q[23:0]};
         default: ext = buf_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         buf_q    <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         signed_q <= 1'b0;
         data_q   <= '0;
         wd_q     <= '0;
         wreg_q   <= 1'b0;
         store_q  <= 1'b0;
      end else if (rdy) begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (access) begin
                  addr_q   <= mem_addr_i;
                  len_q    <= len_in;
                  signed_q <= mem_signed_i;
                  data_q   <= wdata_i;
                  wd_q     <= wd_i;
                  wreg_q   <= wreg_i;
                  // Both request bits set resolves to a load.
                  store_q  <= storing_i & ~loading_i;
                  cnt_q    <= '0;
                  buf_q    <= '0;
               end
            end
            BUSY: begin
               if (mem_gnt_i) begin
                  if (!store_q) buf_q[{cnt_q, 3'b000} +: 8] <= mem_din_i;
                  if (!last_byte) cnt_q <= cnt_q + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_a_o     = '0;
      mem_dout_o  = '0;
      stall_req_o = 1'b0;
      wd_o        = wd_i;
      wreg_o      = wreg_i;
      wdata_o     = wdata_i;
      case (state_q)
         IDLE: begin
            if (access) begin
               stall_req_o = 1'b1;
               wreg_o      = 1'b0;
               if (rdy) state_d = BUSY;
            end
         end
         BUSY: begin
            // Request outputs depend only on registered state, so they stay
            // put while the controller withholds its grant.
            mem_req_o   = rdy;
            mem_we_o    = store_q;
            mem_a_o     = addr_q + ADDR_W'(cnt_q);
            mem_dout_o  = data_q[{cnt_q, 3'b000} +: 8];
            stall_req_o = 1'b1;
            wd_o        = wd_q;
            wreg_o      = 1'b0;
            wdata_o     = '0;
            if (rdy && mem_gnt_i && last_byte) state_d = DONE;
         end
         DONE: begin
            wd_o    = wd_q;
            wreg_o  = wreg_q;
            wdata_o = store_q ? 32'd0 : ext;
            if (rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset silences every output immediately, including the pass-through.
      if (!rst) begin
         mem_req_o   = 1'b0;
         mem_we_o    = 1'b0;
         mem_a_o     = '0;
         mem_dout_o  = '0;
         stall_req_o = 1'b0;
         wd_o        = '0;
         wreg_o      = 1'b0;
         wdata_o     = '0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic [31:0] wdata_i;
   logic [31:0] mem_addr_i;
   logic        loading_i;
   logic        storing_i;
   logic [2:0]  mem_length_i;
   logic        mem_signed_i;
   logic        mem_gnt_i;
   logic [7:0]  mem_din_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_a_o;
   logic [7:0]  mem_dout_o;
   logic        stall_req_o;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o;

   int checks = 0;
   int errors = 0;

   mem_stage #(.ADDR_W(32), .MAX_LEN(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
      .mem_addr_i(mem_addr_i), .loading_i(loading_i), .storing_i(storing_i),
      .mem_length_i(mem_length_i), .mem_signed_i(mem_signed_i),
      .mem_gnt_i(mem_gnt_i), .mem_din_i(mem_din_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_a_o(mem_a_o),
      .mem_dout_o(mem_dout_o), .stall_req_o(stall_req_o),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string nm, input int idx,
                               input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] actual=%h expected=%h", nm, idx, act, exp);
      end
   endfunction

   typedef struct {
      logic [4:0]  wd;
      logic        wr;
      logic [31:0] wdata;
      logic        ld;
      logic        st;
      logic [2:0]  len;
      logic        exp_stall;
      logic        exp_wreg;
   } pt_t;

   typedef struct {
      logic        ld;
      logic        st;
      logic [2:0]  len;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] data;
      logic [4:0]  wd;
      logic        wr;
      logic [31:0] rbytes;
      int          gap;
      int          nexp;
      logic [31:0] exp;
   } acc_t;

   pt_t  pt_tab[6];
   acc_t acc_tab[12];

   task automatic drive_nop();
      loading_i    = 1'b0;
      storing_i    = 1'b0;
      mem_length_i = 3'd0;
      mem_signed_i = 1'b0;
      mem_addr_i   = 32'h0;
      wdata_i      = 32'h0;
      wd_i         = 5'd0;
      wreg_i       = 1'b0;
   endtask

   // Entered at posedge+1 with the DUT in IDLE; returns at posedge+1 in IDLE.
   // The controller withholds its grant for 'gap' cycles before every byte
   // except the first.
   task automatic run_acc(input acc_t a, input int idx);
      logic [31:0] ea;
      int          waits;
      loading_i    = a.ld;
      storing_i    = a.st;
      mem_length_i = a.len;
      mem_signed_i = a.sg;
      mem_addr_i   = a.addr;
      wdata_i      = a.data;
      wd_i         = a.wd;
      wreg_i       = a.wr;
      mem_gnt_i    = 1'b0;
      #1;
      chk("accept_stall", idx, 32'(stall_req_o), 32'd1);
      chk("accept_wreg",  idx, 32'(wreg_o),      32'd0);
      chk("accept_req",   idx, 32'(mem_req_o),   32'd0);
      @(posedge clk); #1;
      for (int k = 0; k < a.nexp; k++) begin
         ea    = a.addr + 32'(k);
         waits = (k == 0) ? 0 : a.gap;
         for (int w = 0; w <= waits; w++) begin
            mem_gnt_i = (w == waits);
            mem_din_i = a.rbytes[8*k +: 8];
            #1;
            chk("busy_req",   idx, 32'(mem_req_o),   32'd1);
            chk("busy_addr",  idx, mem_a_o,          ea);
            chk("busy_we",    idx, 32'(mem_we_o),    32'(a.st & ~a.ld));
            chk("busy_dout",  idx, 32'(mem_dout_o),  32'(a.data[8*k +: 8]));
            chk("busy_stall", idx, 32'(stall_req_o), 32'd1);
            chk("busy_wreg",  idx, 32'(wreg_o),      32'd0);
            @(posedge clk); #1;
         end
      end
      mem_gnt_i = 1'b0;
      drive_nop();
      #1;
      chk("done_req",   idx, 32'(mem_req_o),   32'd0);
      chk("done_stall", idx, 32'(stall_req_o), 32'd0);
      chk("done_wd",    idx, 32'(wd_o),        32'(a.wd));
      chk("done_wreg",  idx, 32'(wreg_o),      32'(a.wr));
      chk("done_wdata", idx, wdata_o,          a.exp);
      @(posedge clk); #1;
      chk("after_req",   idx, 32'(mem_req_o),   32'd0);
      chk("after_stall", idx, 32'(stall_req_o), 32'd0);
   endtask

   initial begin
      //              wd    wr    wdata          ld    st    len   stall wreg
      pt_tab[0] = '{5'd3,  1'b1, 32'h0000_0005, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1};
      pt_tab[1] = '{5'd9,  1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
      pt_tab[2] = '{5'd4,  1'b0, 32'h1111_2222, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
      pt_tab[3] = '{5'd7,  1'b1, 32'h0000_0100, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0};
      pt_tab[4] = '{5'd2,  1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0};
      pt_tab[5] = '{5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};

      //               ld    st    len   sg    addr           data           wd     wr    rbytes         gap nexp exp
      acc_tab[0]  = '{1'b1, 1'b0, 3'd4, 1'b0, 32'h0000_0100, 32'h0000_0000, 5'd1,  1'b1, 32'h1234_5678, 0, 4, 32'h1234_5678};
      acc_tab[1]  = '{1'b1, 1'b0, 3'd1, 1'b1, 32'h0000_0200, 32'h0000_0000, 5'd2,  1'b1, 32'h0000_0080, 0, 1, 32'hFFFF_FF80};
      acc_tab[2]  = '{1'b1, 1'b0, 3'd1, 1'b0, 32'h0000_0200, 32'h0000_0000, 5'd3,  1'b1, 32'h0000_0080, 0, 1, 32'h0000_0080};
      acc_tab[3]  = '{1'b1, 1'b0, 3'd2, 1'b1, 32'h0000_0204, 32'h0000_0000, 5'd4,  1'b1, 32'h0000_8001, 0, 2, 32'hFFFF_8001};
      acc_tab[4]  = '{1'b1, 1'b0, 3'd2, 1'b0, 32'h0000_0204, 32'h0000_0000, 5'd5,  1'b1, 32'h0000_8001, 0, 2, 32'h0000_8001};
      acc_tab[5]  = '{1'b1, 1'b0, 3'd3, 1'b1, 32'h0000_0300, 32'h0000_0000, 5'd6,  1'b1, 32'h0080_1234, 0, 3, 32'hFF80_1234};
      acc_tab[6]  = '{1'b1, 1'b0, 3'd3, 1'b0, 32'h0000_0300, 32'h0000_0000, 5'd7,  1'b1, 32'hAA80_1234, 0, 3, 32'h0080_1234};
      acc_tab[7]  = '{1'b1, 1'b0, 3'd7, 1'b1, 32'h0000_0400, 32'h0000_0000, 5'd8,  1'b1, 32'h89AB_CDEF, 0, 4, 32'h89AB_CDEF};
      acc_tab[8]  = '{1'b1, 1'b1, 3'd2, 1'b0, 32'h0000_0500, 32'h0000_3344, 5'd9,  1'b1, 32'h0000_7F01, 0, 2, 32'h0000_7F01};
      acc_tab[9]  = '{1'b1, 1'b0, 3'd4, 1'b0, 32'h0000_0600, 32'h0000_0000, 5'd10, 1'b1, 32'hCAFE_F00D, 3, 4, 32'hCAFE_F00D};
      acc_tab[10] = '{1'b0, 1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 5'd11, 1'b0, 32'h0000_0000, 0, 2, 32'h0000_0000};
      acc_tab[11] = '{1'b0, 1'b1, 3'd1, 1'b1, 32'h0000_0010, 32'h1234_5699, 5'd12, 1'b0, 32'h0000_0000, 1, 1, 32'h0000_0000};

      // Reset state: outputs held at zero even with live pass-through inputs.
      rst = 1'b0;
      rdy = 1'b1;
      mem_gnt_i = 1'b0;
      mem_din_i = 8'h00;
      drive_nop();
      wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h0000_1234;
      #12;
      chk("rst_wd",    0, 32'(wd_o),        32'd0);
      chk("rst_wreg",  0, 32'(wreg_o),      32'd0);
      chk("rst_wdata", 0, wdata_o,          32'd0);
      chk("rst_req",   0, 32'(mem_req_o),   32'd0);
      chk("rst_stall", 0, 32'(stall_req_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      drive_nop();

      // IDLE pass-through / stall decisions, checked before any clock edge.
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         wd_i = pt_tab[i].wd; wreg_i = pt_tab[i].wr; wdata_i = pt_tab[i].wdata;
         loading_i = pt_tab[i].ld; storing_i = pt_tab[i].st;
         mem_length_i = pt_tab[i].len; mem_addr_i = 32'h0000_0040;
         #1;
         chk("pt_wd",    i, 32'(wd_o),        32'(pt_tab[i].wd));
         chk("pt_wreg",  i, 32'(wreg_o),      32'(pt_tab[i].exp_wreg));
         chk("pt_wdata", i, wdata_o,          pt_tab[i].wdata);
         chk("pt_stall", i, 32'(stall_req_o), 32'(pt_tab[i].exp_stall));
         chk("pt_req",   i, 32'(mem_req_o),   32'd0);
         drive_nop();
      end
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) run_acc(acc_tab[i], i);

      // rdy low for 4 cycles after the first byte, with a bogus grant/byte
      // presented that must be ignored.
      loading_i = 1'b1; mem_length_i = 3'd4; mem_addr_i = 32'h0000_0700;
      wd_i = 5'd13; wreg_i = 1'b1;
      @(posedge clk); #1;
      mem_gnt_i = 1'b1; mem_din_i = 8'hDD;
      #1;
      chk("rdy_a0", 0, mem_a_o, 32'h0000_0700);
      @(posedge clk); #1;
      rdy = 1'b0; mem_din_i = 8'h00;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk("rdy_freeze_req",   c, 32'(mem_req_o),   32'd0);
         chk("rdy_freeze_stall", c, 32'(stall_req_o), 32'd1);
         @(posedge clk); #1;
      end
      rdy = 1'b1;
      for (int k = 1; k < 4; k++) begin
         mem_gnt_i = 1'b1;
         mem_din_i = (k == 1) ? 8'hCC : ((k == 2) ? 8'hBB : 8'hAA);
         #1;
         chk("rdy_addr", k, mem_a_o, 32'h0000_0700 + 32'(k));
         chk("rdy_req",  k, 32'(mem_req_o), 32'd1);
         @(posedge clk); #1;
      end
      mem_gnt_i = 1'b0;
      drive_nop();
      #1;
      chk("rdy_done_wdata", 0, wdata_o,        32'hAABB_CCDD);
      chk("rdy_done_wreg",  0, 32'(wreg_o),    32'd1);
      chk("rdy_done_stall", 0, 32'(stall_req_o), 32'd0);
      @(posedge clk); #1;

      // Reset in BUSY after the first byte: everything drops at once.
      loading_i = 1'b1; mem_length_i = 3'd4; mem_addr_i = 32'h0000_0800;
      wd_i = 5'd14; wreg_i = 1'b1; wdata_i = 32'h0000_0055;
      @(posedge clk); #1;
      mem_gnt_i = 1'b1; mem_din_i = 8'h11;
      @(posedge clk); #1;
      mem_gnt_i = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      chk("midrst_req",   0, 32'(mem_req_o),   32'd0);
      chk("midrst_stall", 0, 32'(stall_req_o), 32'd0);
      chk("midrst_addr",  0, mem_a_o,          32'd0);
      chk("midrst_wdata", 0, wdata_o,          32'd0);
      chk("midrst_wd",    0, 32'(wd_o),        32'd0);
      drive_nop();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_acc(acc_tab[0], 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
